// File: rtl/traffic_sensor_cond.sv
// Two-channel loop-detector conditioner: synchronize, debounce, hold occupancy, pulse and count vehicles.
// Build option: define TSC_VEH_COUNT_EN to implement the saturating per-street vehicle counters.
module traffic_sensor_cond #(
   parameter int DEB_CYCLES  = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             det_a_i,
   input  logic             det_b_i,
   input  logic             cnt_clr_i,
   output logic             ta_o,
   output logic             tb_o,
   output logic             car_a_o,
   output logic             car_b_o,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_b_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_OCC  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   logic [1:0]       w_det;
   logic [1:0]       w_occ;
   logic [1:0]       w_car;
   logic [CNT_W-1:0] w_veh [2];

   assign w_det = {det_b_i, det_a_i};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0] r_sync;
      state_t     r_state;
      state_t     w_state_next;
      logic [7:0] r_cnt;
      logic [7:0] w_cnt_next;
      logic       w_det_s;
      logic       w_hit;
      logic       r_occ;
      logic       r_car;

      assign w_det_s = r_sync[1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_occ   <= 1'b0;
            r_car   <= 1'b0;
         end else begin
            r_sync  <= {r_sync[0], w_det[gi]};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_occ   <= (w_state_next == ST_OCC) || (w_state_next == ST_HOLD);
            r_car   <= w_hit;
         end
      end

      // w_hit marks only the debounced QUAL->OCC entry; re-entry from HOLD is the same vehicle
      always_comb begin
         w_state_next = ST_IDLE;
         w_cnt_next   = r_cnt;
         w_hit        = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_det_s) begin
                  w_state_next = ST_QUAL;
                  w_cnt_next   = 8'd1;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
            ST_QUAL: begin
               if (!w_det_s) begin
                  w_state_next = ST_IDLE;
               end else if (r_cnt == DEB_LAST) begin
                  w_state_next = ST_OCC;
                  w_hit        = 1'b1;
               end else begin
                  w_state_next = ST_QUAL;
                  w_cnt_next   = r_cnt + 8'd1;
               end
            end
            ST_OCC: begin
               if (!w_det_s) begin
                  w_state_next = ST_HOLD;
                  w_cnt_next   = 8'd1;
               end else begin
                  w_state_next = ST_OCC;
               end
            end
            ST_HOLD: begin
               if (w_det_s) begin
                  w_state_next = ST_OCC;
               end else if (r_cnt == HOLD_LAST) begin
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_HOLD;
                  w_cnt_next   = r_cnt + 8'd1;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end

      assign w_occ[gi] = r_occ;
      assign w_car[gi] = r_car;

`ifdef TSC_VEH_COUNT_EN
      logic [CNT_W-1:0] r_veh;

      // clear wins over a same-cycle qualification; count sticks at all-ones
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_veh <= '0;
         end else if (cnt_clr_i) begin
            r_veh <= '0;
         end else if (w_hit && (r_veh != {CNT_W{1'b1}})) begin
            r_veh <= r_veh + CNT_W'(1);
         end
      end

      assign w_veh[gi] = r_veh;
`else
      assign w_veh[gi] = '0;
`endif
   end

`ifndef TSC_VEH_COUNT_EN
   logic w_unused_clr;
   assign w_unused_clr = cnt_clr_i;
`endif

   assign ta_o    = w_occ[0];
   assign tb_o    = w_occ[1];
   assign car_a_o = w_car[0];
   assign car_b_o = w_car[1];
   assign cnt_a_o = w_veh[0];
   assign cnt_b_o = w_veh[1];

endmodule
